viterbi_deinterleaver: RTL and testbench

Receive-side 802.11a block deinterleaver sitting directly upstream of the Viterbi decoder. It accepts demapped coded bits serially, one per cycle, and buffers one OFDM symbol of NCBPS bits in a ping-pong memory. It undoes both transmit permutations and emits the symbol as 2-bit coded pairs {A,B} with a valid strobe, in the format the decoder's `Vinput`/`enable` pins consume.

---
 rtl/viterbi_deinterleaver_if.sv | 23 ++
 rtl/viterbi_deinterleaver.sv | 182 ++++++++++++++++++
 tb/tb_viterbi_deinterleaver.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/viterbi_deinterleaver_if.sv
// viterbi_deinterleaver_if: serial coded-bit input and coded-pair output of the
// receive-side deinterleaver. The master drives bits in; the slave (the
// deinterleaver) returns {A,B} pairs with a valid strobe.
interface viterbi_deinterleaver_if;
    logic       enable;       // input strobe for Dinput
    logic       Dinput;       // demapped coded bit, interleaved order
    logic       outputValid;  // Voutput carries a valid pair
    logic [1:0] Voutput;      // {A (even coded index), B (odd coded index)}

    modport master (
        output enable,
        output Dinput,
        input  outputValid,
        input  Voutput
    );

    modport slave (
        input  enable,
        input  Dinput,
        output outputValid,
        output Voutput
    );
endinterface

// File: rtl/viterbi_deinterleaver.sv
// viterbi_deinterleaver: 802.11a receive block deinterleaver ahead of the
// Viterbi decoder. Bits arrive one per enabled cycle, are scattered into the
// write bank of a ping-pong memory at their deinterleaved address, and a full
// symbol is drained as NCBPS/2 consecutive {A,B} pairs.
// Optional feature macro: DEINT_PERM2_EN compiles in the second (s-term)
// permutation needed for NBPSC > 2; without it the block uses i = j.
module viterbi_deinterleaver #(
    parameter int unsigned NCBPS = 48,
    parameter int unsigned NBPSC = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    viterbi_deinterleaver_if.slave bus
);

    localparam int unsigned D  = NCBPS / 16;
    localparam int unsigned AW = $clog2(NCBPS);
    localparam int unsigned MW = AW - 1;

    localparam logic [8:0]    JLast = 9'(NCBPS - 1);
    localparam logic [4:0]    CLast = 5'(D - 1);
    localparam logic [MW-1:0] MLast = MW'(NCBPS / 2 - 1);

    typedef enum logic {StIdle, StDrain} state_e;

    // Write side: j counts accepted bits, r = floor(j/D), c = j mod D.
    logic [8:0]    r_j;
    logic [3:0]    r_r;
    logic [4:0]    r_c;
    logic          r_wbank;
    logic          w_rbank;
    logic          w_swap;
    logic [4:0]    w_col;
    logic [3:0]    w_row;
    logic [AW-1:0] w_addr;

    // Read side.
    state_e        r_state;
    logic [MW-1:0] r_m;
    logic          r_valid;
    logic [1:0]    r_pair;
    logic [AW-1:0] w_rd0;
    logic [AW-1:0] w_rd1;

    logic          r_mem [2][NCBPS];

    assign w_swap  = bus.enable && (r_j == JLast);
    assign w_rbank = ~r_wbank;

    // Write-side index counters and bank select; the last bit of a symbol swaps banks.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_j     <= '0;
            r_r     <= '0;
            r_c     <= '0;
            r_wbank <= 1'b0;
        end else if (bus.enable) begin
            if (w_swap) begin
                r_j     <= '0;
                r_r     <= '0;
                r_c     <= '0;
                r_wbank <= ~r_wbank;
            end else begin
                r_j <= r_j + 9'd1;
                if (r_c == CLast) begin
                    r_c <= '0;
                    r_r <= r_r + 4'd1;
                end else begin
                    r_c <= r_c + 5'd1;
                end
            end
        end
    end

`ifdef DEINT_PERM2_EN
    localparam int unsigned       S      = (NBPSC / 2 > 1) ? NBPSC / 2 : 1;
    localparam logic [1:0]        SLast  = 2'(S - 1);
    localparam logic [2:0]        SVal   = 3'(S);
    localparam logic signed [6:0] DVal   = 7'(D);
    localparam logic signed [6:0] CLastS = 7'(D - 1);

    logic [1:0]        r_js;   // j mod s
    logic [1:0]        r_rm;   // r mod s
    logic [2:0]        w_sum;
    logic [1:0]        w_t;
    logic signed [6:0] w_ci;
    logic signed [6:0] w_adj;

    // Track j mod s and r mod s alongside j and r so no divider is needed.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_js <= '0;
            r_rm <= '0;
        end else if (bus.enable) begin
            if (w_swap) begin
                r_js <= '0;
                r_rm <= '0;
            end else begin
                r_js <= (r_js == SLast) ? 2'd0 : r_js + 2'd1;
                if (r_c == CLast) begin
                    r_rm <= (r_rm == SLast) ? 2'd0 : r_rm + 2'd1;
                end
            end
        end
    end

    // i = j - (j mod s) + ((j mod s + r mod s) mod s); i is within s-1 of j, so
    // its row/column split differs from (r, c) by at most one column wrap.
    always_comb begin
        w_sum = {1'b0, r_js} + {1'b0, r_rm};
        w_t   = (w_sum >= SVal) ? 2'(w_sum - SVal) : w_sum[1:0];
        w_ci  = $signed({2'b00, r_c}) + $signed({5'b00000, w_t}) - $signed({5'b00000, r_js});
        w_adj = w_ci;
        w_row = r_r;
        if (w_ci < 7'sd0) begin
            w_adj = w_ci + DVal;
            w_row = r_r - 4'd1;
        end else if (w_ci > CLastS) begin
            w_adj = w_ci - DVal;
            w_row = r_r + 4'd1;
        end
        w_col = 5'(w_adj);
    end
`else
    assign w_col = r_c;
    assign w_row = r_r;

    // NBPSC > 2 needs the s-term permutation; this build would emit a wrong order.
    if (NBPSC > 2) begin : g_nbpsc_unsupported
    end
`endif

    // k = 16 * (i mod D) + floor(i / D)
    assign w_addr = AW'({w_col, 4'b0000} + {5'b00000, w_row});

    assign w_rd0 = {r_m, 1'b0};
    assign w_rd1 = {r_m, 1'b1};

    // Ping-pong storage; contents need no reset.
    always_ff @(posedge clock) begin
        if (bus.enable) begin
            r_mem[r_wbank][w_addr] <= bus.Dinput;
        end
    end

    // Drain FSM: one pair per cycle from the read bank, registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
            r_m     <= '0;
            r_valid <= 1'b0;
            r_pair  <= 2'b00;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_valid <= 1'b0;
                    if (w_swap) begin
                        r_state <= StDrain;
                        r_m     <= '0;
                    end
                end
                StDrain: begin
                    r_valid <= 1'b1;
                    r_pair  <= {r_mem[w_rbank][w_rd0], r_mem[w_rbank][w_rd1]};
                    if (r_m == MLast) begin
                        r_m <= '0;
                        // A swap on the final pair's edge chains straight into the next drain.
                        if (!w_swap) begin
                            r_state <= StIdle;
                        end
                    end else begin
                        r_m <= r_m + MW'(1);
                    end
                end
            endcase
        end
    end

    assign bus.outputValid = r_valid;
    assign bus.Voutput     = r_pair;

endmodule

// File: tb/tb_viterbi_deinterleaver.sv
// tb_viterbi_deinterleaver: directed checks on a 48-bit/NBPSC=1 instance and a
// 192-bit instance (NBPSC=4 with DEINT_PERM2_EN, NBPSC=2 without).
module tb_viterbi_deinterleaver;

    localparam int unsigned N1 = 48;
    localparam int unsigned N2 = 192;
`ifdef DEINT_PERM2_EN
    localparam int unsigned NB2  = 4;
    localparam int          K_J12 = 17;  // i=13 -> c=1, r=1
    localparam int          K_J13 = 1;   // i=12 -> c=0, r=1
`else
    localparam int unsigned NB2  = 2;
    localparam int          K_J12 = 1;
    localparam int          K_J13 = 17;
`endif

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    viterbi_deinterleaver_if if1 ();
    viterbi_deinterleaver_if if2 ();

    viterbi_deinterleaver #(.NCBPS(N1), .NBPSC(1)) u_dut1 (
        .clock (clk),
        .reset (rst),
        .bus   (if1)
    );

    viterbi_deinterleaver #(.NCBPS(N2), .NBPSC(NB2)) u_dut2 (
        .clock (clk),
        .reset (rst),
        .bus   (if2)
    );

    initial begin
`ifndef DEINT_PERM2_EN
        if (NB2 > 2) $display("ERROR: NBPSC=%0d requires DEINT_PERM2_EN", NB2);
`endif
    end

    // Output capture, sampled on the falling edge.
    logic [1:0] q1_pair[$];
    int         q1_cyc[$];
    logic [1:0] q2_pair[$];
    int         q2_cyc[$];

    always @(negedge clk) begin
        if (if1.outputValid === 1'b1) begin
            q1_pair.push_back(if1.Voutput);
            q1_cyc.push_back(cyc);
        end
        if (if2.outputValid === 1'b1) begin
            q2_pair.push_back(if2.Voutput);
            q2_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic en, input logic d);
        if (sel == 0) begin
            if1.enable = en;
            if1.Dinput = d;
        end else begin
            if2.enable = en;
            if2.Dinput = d;
        end
    endtask

    task automatic idle(input int n);
        drive(0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0);
        repeat (n) @(negedge clk);
    endtask

    // Sends bits v[0..n-1] in order; t_last is the edge that accepted the last one.
    task automatic send_sym(input int sel, input logic [287:0] v, input int n,
                            input int gap_pct, output int t_last);
        t_last = -1;
        for (int j = 0; j < n; j++) begin
            for (int g = 0; g < 3 && gap_pct > 0 && int'($urandom_range(99)) < gap_pct; g++) begin
                drive(sel, 1'b0, 1'b0);
                @(negedge clk);
            end
            drive(sel, 1'b1, v[j]);
            @(negedge clk);
            t_last = cyc;
        end
        drive(sel, 1'b0, 1'b0);
    endtask

    // Transmit interleaver (both permutations) taking coded order to received order.
    function automatic logic [287:0] interleave(input logic [287:0] x, input int n, input int nbpsc);
        logic [287:0] rx;
        int s;
        int i;
        int j;
        rx = '0;
        s  = (nbpsc / 2 > 1) ? nbpsc / 2 : 1;
        for (int k = 0; k < n; k++) begin
            i = (n / 16) * (k % 16) + k / 16;
            j = s * (i / s) + (i + n - (16 * i) / n) % s;
            rx[j] = x[k];
        end
        return rx;
    endfunction

    // Pops np pairs; pair m must be {e[2m], e[2m+1]} presented at cycle t0+m.
    task automatic check_drain(input int sel, input string tag, input logic [287:0] e,
                               input int np, input int t0);
        int         avail;
        logic [1:0] p;
        int         c;
        avail = (sel == 0) ? q1_pair.size() : q2_pair.size();
        check({tag, " count"}, (avail >= np) ? np : avail, np);
        for (int m = 0; m < np && m < avail; m++) begin
            if (sel == 0) begin
                p = q1_pair.pop_front();
                c = q1_cyc.pop_front();
            end else begin
                p = q2_pair.pop_front();
                c = q2_cyc.pop_front();
            end
            check($sformatf("%s pair%0d", tag, m), p, {e[2*m], e[2*m+1]});
            check($sformatf("%s cyc%0d", tag, m), c, t0 + m);
        end
    endtask

    initial begin
        logic [287:0] v;
        logic [287:0] e;
        logic [287:0] x1;
        logic [287:0] x2;
        logic [287:0] x3;
        int           t;
        int           t2;

        rst = 1'b1;
        drive(0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("reset valid1", if1.outputValid, 0);
        check("reset vout1", if1.Voutput, 0);
        check("reset valid2", if2.outputValid, 0);
        check("reset vout2", if2.Voutput, 0);
        rst = 1'b0;
        idle(2);

        for (int b = 0; b < 288; b++) begin
            x1[b] = 1'($urandom_range(1));
            x2[b] = 1'($urandom_range(1));
            x3[b] = 1'($urandom_range(1));
        end

        // Single '1' at j=1 lands at k=16 -> pair 8 = 2'b10.
        v = '0; v[1] = 1'b1;
        e = '0; e[16] = 1'b1;
        send_sym(0, v, 48, 0, t);
        idle(30);
        check_drain(0, "j1", e, 24, t + 1);
        check("j1 extra", q1_pair.size(), 0);

        // Single '1' at j=3 lands at k=1 -> pair 0 = 2'b01; valid T+1..T+24.
        v = '0; v[3] = 1'b1;
        e = '0; e[1] = 1'b1;
        send_sym(0, v, 48, 0, t);
        idle(30);
        check_drain(0, "j3", e, 24, t + 1);
        check("j3 extra", q1_pair.size(), 0);

        // Two symbols back-to-back, golden data through the bench interleaver.
        send_sym(0, interleave(x1, 48, 1), 48, 0, t);
        send_sym(0, interleave(x2, 48, 1), 48, 0, t2);
        idle(30);
        check_drain(0, "b2b s0", x1, 24, t + 1);
        check_drain(0, "b2b s1", x2, 24, t2 + 1);
        check("b2b extra", q1_pair.size(), 0);

        // Enable gaps within the symbol, then toggling enable during the drain.
        send_sym(0, interleave(x1, 48, 1), 48, 30, t);
        for (int g = 0; g < 24; g++) begin
            drive(0, 1'($urandom_range(1)), 1'b1);
            @(negedge clk);
        end
        idle(10);
        check_drain(0, "gaps", x1, 24, t + 1);
        check("gaps extra", q1_pair.size(), 0);

        // Reset after 20 bits of a symbol; the partial symbol must vanish.
        send_sym(0, interleave(x3, 48, 1), 20, 0, t);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(60);
        check("partial no output", q1_pair.size(), 0);
        send_sym(0, interleave(x2, 48, 1), 48, 0, t);
        idle(30);
        check_drain(0, "after rst", x2, 24, t + 1);
        check("after rst extra", q1_pair.size(), 0);

        // 192-bit instance: single-bit placements.
        v = '0; v[12] = 1'b1;
        e = '0; e[K_J12] = 1'b1;
        send_sym(1, v, 192, 0, t);
        idle(110);
        check_drain(1, "n192 j12", e, 96, t + 1);
        check("n192 j12 extra", q2_pair.size(), 0);

        v = '0; v[13] = 1'b1;
        e = '0; e[K_J13] = 1'b1;
        send_sym(1, v, 192, 0, t);
        idle(110);
        check_drain(1, "n192 j13", e, 96, t + 1);
        check("n192 j13 extra", q2_pair.size(), 0);

        // 192-bit instance: golden symbol with gaps.
        send_sym(1, interleave(x3, 192, int'(NB2)), 192, 30, t);
        idle(110);
        check_drain(1, "n192 gold", x3, 96, t + 1);
        check("n192 gold extra", q2_pair.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
